// File: rtl/sys_ctrl_burst.sv
// sys_ctrl_burst: UART command decoder driving register file, ALU and TX FIFO.
// Define SYS_CTRL_BURST_CMD_EN to decode the 0xEE/0xFF burst commands.
module sys_ctrl_burst #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int FUN_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    REF_CLK,
    input  logic                    RST_N,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_D_VLD,
    input  logic                    FIFO_FULL,
    output logic                    WrEn,
    output logic                    RdEn,
    output logic [ADDR_WIDTH-1:0]   Address,
    output logic [DATA_WIDTH-1:0]   WrData,
    input  logic [DATA_WIDTH-1:0]   RdData,
    input  logic                    RdData_Valid,
    output logic                    ALU_EN,
    output logic [FUN_WIDTH-1:0]    ALU_FUN,
    output logic                    CLK_GATE_EN,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    ALU_OUT_VLD,
    output logic                    CMD_ERR
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] C_WR  = 3'd0;
    localparam logic [2:0] C_RD  = 3'd1;
    localparam logic [2:0] C_ALU = 3'd2;
`ifdef SYS_CTRL_BURST_CMD_EN
    localparam logic [2:0] C_BW  = 3'd3;
    localparam logic [2:0] C_BR  = 3'd4;
`endif

    typedef enum logic [3:0] {
        IDLE, GET_ADDR, GET_LEN, GET_DATA, GET_OPA, GET_OPB,
        GET_FUN, RD_REQ, RD_WAIT, ALU_REQ, ALU_WAIT, TX_PUSH
    } state_e;

    state_e state_q, state_d;

    logic [2:0]              cmd_q, cmd_d, cmd_new;
    logic                    cmd_hit;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [2*DATA_WIDTH-1:0] res_q, res_d;
    logic                    frame_q, frame_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic                    in_get, tmo_hit, more_data, more_rd;

    logic                    wr_en_q, wr_en_d;
    logic                    rd_en_q, rd_en_d;
    logic                    alu_en_q, alu_en_d;
    logic                    tx_vld_q, tx_vld_d;
    logic                    err_q, err_d;
    logic                    gate_q, gate_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic [FUN_WIDTH-1:0]    alu_fun_q, alu_fun_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;

`ifdef SYS_CTRL_BURST_CMD_EN
    logic [DATA_WIDTH-1:0]   len_q, len_d;

    // len_q counts bytes still outstanding, including the current one
    assign more_data = (cmd_q == C_BW) && (len_q != DATA_WIDTH'(1));
    assign more_rd   = (cmd_q == C_BR) && (len_q != DATA_WIDTH'(1));
`else
    assign more_data = 1'b0;
    assign more_rd   = 1'b0;
`endif

    assign in_get = (state_q == GET_ADDR) || (state_q == GET_LEN) ||
                    (state_q == GET_DATA) || (state_q == GET_OPA) ||
                    (state_q == GET_OPB)  || (state_q == GET_FUN);

    assign tmo_hit = in_get && !RX_D_VLD &&
                     (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cmd_hit = 1'b1;
        cmd_new = C_WR;
        case (RX_P_DATA)
            DATA_WIDTH'(8'hAA): cmd_new = C_WR;
            DATA_WIDTH'(8'hBB): cmd_new = C_RD;
            DATA_WIDTH'(8'hCC): cmd_new = C_ALU;
            DATA_WIDTH'(8'hDD): cmd_new = C_ALU;
`ifdef SYS_CTRL_BURST_CMD_EN
            DATA_WIDTH'(8'hEE): cmd_new = C_BW;
            DATA_WIDTH'(8'hFF): cmd_new = C_BR;
`endif
            default:            cmd_hit = 1'b0;
        endcase
    end

    always_ff @(posedge REF_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            cmd_q     <= C_WR;
            ptr_q     <= '0;
            res_q     <= '0;
            frame_q   <= 1'b0;
            tmo_q     <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            alu_en_q  <= 1'b0;
            tx_vld_q  <= 1'b0;
            err_q     <= 1'b0;
            gate_q    <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
            alu_fun_q <= '0;
            tx_data_q <= '0;
`ifdef SYS_CTRL_BURST_CMD_EN
            len_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            ptr_q     <= ptr_d;
            res_q     <= res_d;
            frame_q   <= frame_d;
            tmo_q     <= tmo_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            alu_en_q  <= alu_en_d;
            tx_vld_q  <= tx_vld_d;
            err_q     <= err_d;
            gate_q    <= gate_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            alu_fun_q <= alu_fun_d;
            tx_data_q <= tx_data_d;
`ifdef SYS_CTRL_BURST_CMD_EN
            len_q     <= len_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (RX_D_VLD && cmd_hit) begin
                    if (RX_P_DATA == DATA_WIDTH'(8'hCC))
                        state_d = GET_OPA;
                    else if (RX_P_DATA == DATA_WIDTH'(8'hDD))
                        state_d = GET_FUN;
                    else
                        state_d = GET_ADDR;
                end
            end
            GET_ADDR: begin
                if (RX_D_VLD) begin
                    if (cmd_q == C_WR)
                        state_d = GET_DATA;
`ifdef SYS_CTRL_BURST_CMD_EN
                    else if (cmd_q != C_RD)
                        state_d = GET_LEN;
`endif
                    else
                        state_d = RD_REQ;
                end
            end
`ifdef SYS_CTRL_BURST_CMD_EN
            GET_LEN: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == '0)
                        state_d = IDLE;
                    else if (cmd_q == C_BW)
                        state_d = GET_DATA;
                    else
                        state_d = RD_REQ;
                end
            end
`endif
            GET_DATA: if (RX_D_VLD && !more_data) state_d = IDLE;
            GET_OPA:  if (RX_D_VLD) state_d = GET_OPB;
            GET_OPB:  if (RX_D_VLD) state_d = GET_FUN;
            GET_FUN:  if (RX_D_VLD) state_d = ALU_REQ;
            RD_REQ, RD_WAIT:
                state_d = RdData_Valid ? TX_PUSH : RD_WAIT;
            ALU_REQ, ALU_WAIT:
                state_d = ALU_OUT_VLD ? TX_PUSH : ALU_WAIT;
            TX_PUSH: begin
                if (!FIFO_FULL) begin
                    if (cmd_q == C_ALU && !frame_q)
                        state_d = TX_PUSH;
                    else if (more_rd)
                        state_d = RD_REQ;
                    else
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (tmo_hit)
            state_d = IDLE;
    end

    always_comb begin
        cmd_d     = cmd_q;
        ptr_d     = ptr_q;
        res_d     = res_q;
        frame_d   = frame_q;
        tmo_d     = '0;
        wr_en_d   = 1'b0;
        tx_vld_d  = 1'b0;
        err_d     = 1'b0;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        alu_fun_d = alu_fun_q;
        tx_data_d = tx_data_q;
`ifdef SYS_CTRL_BURST_CMD_EN
        len_d     = len_q;
`endif
        if (in_get && !RX_D_VLD)
            tmo_d = tmo_q + TW'(1);
        case (state_q)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (cmd_hit) cmd_d = cmd_new;
                    else         err_d = 1'b1;
                end
            end
            GET_ADDR: if (RX_D_VLD) ptr_d = RX_P_DATA[ADDR_WIDTH-1:0];
`ifdef SYS_CTRL_BURST_CMD_EN
            GET_LEN:  if (RX_D_VLD) len_d = RX_P_DATA;
`endif
            GET_DATA: begin
                if (RX_D_VLD) begin
                    wr_en_d   = 1'b1;
                    addr_d    = ptr_q;
                    wr_data_d = RX_P_DATA;
                    ptr_d     = ptr_q + ADDR_WIDTH'(1);
`ifdef SYS_CTRL_BURST_CMD_EN
                    len_d     = len_q - DATA_WIDTH'(1);
`endif
                end
            end
            GET_OPA, GET_OPB: begin
                if (RX_D_VLD) begin
                    wr_en_d   = 1'b1;
                    addr_d    = (state_q == GET_OPB) ? ADDR_WIDTH'(1) : '0;
                    wr_data_d = RX_P_DATA;
                end
            end
            GET_FUN: if (RX_D_VLD) alu_fun_d = RX_P_DATA[FUN_WIDTH-1:0];
            RD_REQ, RD_WAIT: begin
                err_d = RX_D_VLD;
                if (RdData_Valid)
                    res_d = {{DATA_WIDTH{1'b0}}, RdData};
            end
            ALU_REQ, ALU_WAIT: begin
                err_d   = RX_D_VLD;
                frame_d = 1'b0;
                if (ALU_OUT_VLD)
                    res_d = ALU_OUT;
            end
            TX_PUSH: begin
                err_d = RX_D_VLD;
                if (!FIFO_FULL) begin
                    tx_vld_d  = 1'b1;
                    tx_data_d = res_q[DATA_WIDTH-1:0];
                    res_d     = res_q >> DATA_WIDTH;
                    frame_d   = 1'b1;
                    if (more_rd) begin
                        ptr_d = ptr_q + ADDR_WIDTH'(1);
`ifdef SYS_CTRL_BURST_CMD_EN
                        len_d = len_q - DATA_WIDTH'(1);
`endif
                    end
                end
            end
            default: ;
        endcase
        // every read issue points Address at the pointer it is about to use
        if (state_d == RD_REQ)
            addr_d = ptr_d;
        if (tmo_hit)
            err_d = 1'b1;
    end

    assign rd_en_d  = (state_d == RD_REQ);
    assign alu_en_d = (state_d == ALU_REQ);
    assign gate_d   = (cmd_d == C_ALU) && (state_d != IDLE);

    assign TX_P_DATA   = tx_data_q;
    assign TX_D_VLD    = tx_vld_q;
    assign WrEn        = wr_en_q;
    assign RdEn        = rd_en_q;
    assign Address     = addr_q;
    assign WrData      = wr_data_q;
    assign ALU_EN      = alu_en_q;
    assign ALU_FUN     = alu_fun_q;
    assign CLK_GATE_EN = gate_q;
    assign CMD_ERR     = err_q;

endmodule

// File: doc/sys_ctrl_burst.md
# sys_ctrl_burst

Parametrised command controller for the processing system. It sits in the REF_CLK domain between the synchronised UART RX byte stream and three other blocks: the register file, the ALU and the TX FIFO. It decodes framed commands (write, read, ALU with operands, ALU without operands, and optionally burst write and burst read) and drives the register file and ALU. Responses are pushed into the TX FIFO, and an ALU result wider than one frame is split across several frames.

## Interface
Parameters:
- DATA_WIDTH, 8, width of one UART frame, one register and one ALU operand
- ADDR_WIDTH, 4, register-file address width; address bytes are truncated to their low ADDR_WIDTH bits
- FUN_WIDTH, 4, ALU function code width; the low FUN_WIDTH bits of the function byte are used
- TIMEOUT_CYCLES, 4096, number of REF_CLK cycles allowed between bytes of one command before the command is aborted

Ports (the clock is REF_CLK and the reset is RST_N, asynchronous and active-low):
- REF_CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- RX_P_DATA  in  DATA_WIDTH  received byte
- RX_D_VLD  in  1  one-cycle strobe marking a valid RX_P_DATA
- TX_P_DATA  out  DATA_WIDTH  byte to be pushed into the TX FIFO
- TX_D_VLD  out  1  one-cycle push strobe
- FIFO_FULL  in  1  TX FIFO full; no push is allowed while it is high
- WrEn  out  1  register-file write strobe
- RdEn  out  1  register-file read strobe
- Address  out  ADDR_WIDTH  register-file address
- WrData  out  DATA_WIDTH  register-file write data
- RdData  in  DATA_WIDTH  register-file read data
- RdData_Valid  in  1  read data valid
- ALU_EN  out  1  ALU start strobe
- ALU_FUN  out  FUN_WIDTH  ALU function code
- CLK_GATE_EN  out  1  ALU clock-gate enable
- ALU_OUT  in  2*DATA_WIDTH  ALU result
- ALU_OUT_VLD  in  1  ALU result valid
- CMD_ERR  out  1  one-cycle error pulse

## Operation
Commands (first byte) and the bytes that follow:
- 0xAA: address, data. Write the data to the address.
- 0xBB: address. Read the address and send 1 frame.
- 0xCC: A, B, fun. Write A to address 0 and B to address 1, then run the ALU and send the result.
- 0xDD: fun. Run the ALU and send the result.
- 0xEE: address, length, then length data bytes. Burst write.
- 0xFF: address, length. Burst read; send length frames.

State machine:
- States: IDLE, GET_ADDR, GET_LEN, GET_DATA, GET_OPA, GET_OPB, GET_FUN, RD_REQ, RD_WAIT, ALU_REQ, ALU_WAIT, TX_PUSH.
- IDLE: exits only on RX_D_VLD carrying a known command. An unknown command byte pulses CMD_ERR and the FSM stays in IDLE.
- Writes: every data byte produces one WrEn cycle in the cycle after it is accepted.
  - Burst writes use the address for byte 0, address+1 for byte 1, and so on.
  - Address arithmetic is modulo 2^ADDR_WIDTH, so 0xF wraps to 0x0.
- Reads: the FSM issues RdEn for one cycle, waits in RD_WAIT for RdData_Valid, then goes to TX_PUSH.
  - TX_PUSH holds the data until FIFO_FULL is 0, then issues one TX_D_VLD.
  - A burst read repeats this per byte with an incrementing, wrapping address.
- ALU: CLK_GATE_EN rises when 0xCC or 0xDD is decoded and falls after the last result frame is pushed.
  - ALU_EN pulses for one cycle, with ALU_FUN valid, in the cycle after the fun byte is accepted.
  - ALU_OUT is latched on ALU_OUT_VLD.
  - The result is sent as ceil(2*DATA_WIDTH/DATA_WIDTH) = 2 frames, low byte first.
- Length 0 (0xEE or 0xFF): no write, read or push. The FSM returns to IDLE and the command is not an error.
- An RX_D_VLD arriving in RD_REQ, RD_WAIT, ALU_REQ, ALU_WAIT or TX_PUSH: the byte is dropped, CMD_ERR pulses, and the current command runs to completion.
- Timeout: while in a GET_* state, the timeout counter reloads on every accepted byte. If it reaches TIMEOUT_CYCLES, the FSM pulses CMD_ERR and returns to IDLE; no partial write of the missing byte occurs.
- Reset: asynchronous, at any time. The FSM goes to IDLE and every output goes to 0. Any in-flight command is discarded with no further strobes.

## Timing
- Reset value of every output is 0. The FSM and all counters reset to IDLE and 0.
- All strobes (WrEn, RdEn, ALU_EN, TX_D_VLD, CMD_ERR) last exactly one cycle and are registered.
- Write latency: WrEn is asserted 1 cycle after the RX_D_VLD of the data byte.
- Read latency: RdEn is asserted 1 cycle after the address (or length) byte. TX_D_VLD is asserted no earlier than 1 cycle after RdData_Valid, and only in cycles where FIFO_FULL is 0.
- Burst accept rate: one byte is accepted per RX_D_VLD; back-to-back RX_D_VLD strobes in consecutive cycles must all be accepted.
- Address and WrData stay stable during the WrEn cycle. Address stays stable from RdEn until RdData_Valid.

## Configuration
- Macro: SYS_CTRL_BURST_CMD_EN.
- Defined: 0xEE and 0xFF are decoded as described above, and GET_LEN and the length counter are present.
- Undefined: 0xEE and 0xFF are unknown commands; each one pulses CMD_ERR and the FSM stays in IDLE. The length logic is not synthesised.

## Test plan
- Send 0xAA, 0x05, 0x0A, then 0xBB, 0x05 -> one WrEn with Address=5 and WrData=0x0A; then one TX frame of 0x0A.
- Send 0xCC, 0x01, 0x02, 0x00 with ALU_OUT=0x0003 -> writes to addresses 0 and 1; one ALU_EN with ALU_FUN=0; TX frames 0x03 then 0x00; CLK_GATE_EN low again after the second push.
- With SYS_CTRL_BURST_CMD_EN defined, send 0xEE, 0x0E, 0x03, 0x11, 0x22, 0x33, then 0xFF, 0x0E, 0x03 -> writes to addresses 0xE, 0xF and 0x0; TX frames 0x11, 0x22, 0x33.
- Burst read with FIFO_FULL held high for 50 cycles -> no TX_D_VLD until FIFO_FULL falls; then all frames arrive in order with no loss.
- Send 0xAA, 0x03, then silence for TIMEOUT_CYCLES -> CMD_ERR pulse, no WrEn; a following 0xBB, 0x03 completes normally.
- Send 0x5A; separately, assert RST_N low in the middle of a 0xFF burst -> the first gives CMD_ERR with the FSM staying in IDLE; the second gives all outputs 0 immediately and no further TX_D_VLD.
